mem_access: RTL
===============

Name: mem_access

Overview:
- MEM pipeline stage. Sits between the ex_mem register and the mem_wb register.
- Executes loads and stores as byte-serial transactions through a request/ack port to the memory controller. Extends load data, or passes ALU results straight through.
- Raises a stall request while a transfer is in flight. The stall controller then freezes IF..MEM and bubbles mem_wb (stall[4]=1, stall[5]=0).
- Outputs also feed the ID-stage forwarding path.

Parameters:
- ADDR_W, 32, byte-address width; mem_addr_o wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- exmem_res_in  in  32  ALU result; effective address for load/store.
- exmem_rdest_in  in  5  destination register.
- exmem_we_in  in  1  register write enable.
- exmem_memop_in  in  4  NONE/LB/LH/LW/LBU/LHU/SB/SH/SW.
- exmem_sdata_in  in  32  store data.
- mem_req_o  out  1  byte request valid.
- mem_wr_o  out  1  1=write, 0=read.
- mem_addr_o  out  32  byte address.
- mem_wdata_o  out  8  write byte.
- mem_rdata_i  in  8  read byte, valid with mem_ack_i.
- mem_ack_i  in  1  current byte complete.
- stallreq_mem_o  out  1  stall request to the stall controller.
- mem_res_out  out  32  result to mem_wb and forwarding.
- mem_rdest_out  out  5  destination to mem_wb.
- mem_we_out  out  1  write enable to mem_wb.

Behaviour:
- Size n:
  - 1 for LB/LBU/SB.
  - 2 for LH/LHU/SH.
  - 4 for LW/SW.
- States: IDLE, ACCESS, DONE. Registered byte index k (2 bits) and 24-bit load buffer.
- IDLE:
  - memop != NONE: next state ACCESS, k<=0.
  - Otherwise stay IDLE.
  - No request is issued from IDLE.
- ACCESS:
  - Drives mem_req_o=1, mem_addr_o=exmem_res_in+k, mem_wr_o=store.
  - mem_wdata_o = store byte k of exmem_sdata_in, little-endian.
  - With mem_ack_i=0 at an edge: all outputs held.
  - With mem_ack_i=1 at an edge:
    - Load: byte k captured.
    - k==n-1: next state DONE.
    - Otherwise k<=k+1, and the next request is driven in the following cycle.
- DONE: lasts exactly one cycle, then IDLE unconditionally. The next instruction is presented in the following IDLE cycle.
- Outside ACCESS: mem_req_o=0. mem_wr_o, mem_addr_o and mem_wdata_o are 0. mem_ack_i is ignored.
- stallreq_mem_o (combinational) = (memop != NONE) && state != DONE. It is asserted in the same cycle a memory op first appears in IDLE.
- Result, combinational:
  - memop NONE: passes exmem_res_in, exmem_rdest_in, exmem_we_in.
  - DONE with a load: the assembled word. Final byte is taken directly from mem_rdata_i registered at the last ack. LB/LH sign-extend; LBU/LHU zero-extend.
  - DONE with a store: mem_res_out=0, mem_we_out=0.
  - Any stalled cycle: mem_we_out=0, mem_res_out=0, mem_rdest_out=0.
- Misaligned addresses are legal: bytes are independent. Address addition wraps at 0xFFFFFFFF->0.
- Inputs are held by ex_mem while stallreq_mem_o=1. The block does not re-latch the address or store data.
- rst=0 at any edge:
  - Forces IDLE, k=0, buffer=0, all request outputs 0.
  - An in-flight transfer is abandoned without completing.
  - A stray mem_ack_i after reset is ignored.
- Reset values: every output is 0, except stallreq_mem_o, which follows its combinational equation in IDLE.

Decomposition:
- define.v holds:
  - memop encodings (MemOpBus 3:0, MEM_NONE..MEM_SW).
  - RegBus and RegAddrBus.
  - MEM state encodings.
- One natural sub-module: load_extend. It is combinational: memop plus a 32-bit raw word in, extended 32-bit result out.

Test Plan:
- ADD passthrough: memop NONE, res=0x1234, rdest=5, we=1 -> same values on outputs in the same cycle; stallreq=0; mem_req=0.
- LW 0x100 with bytes 0x78,0x56,0x34,0x12, each acked the cycle it is requested:
  - stallreq high for 5 cycles (IDLE + 4 ACCESS).
  - Addresses 0x100..0x103.
  - DONE outputs res=0x12345678, we=1.
- LB 0x3 returning 0x80 -> res=0xFFFFFF80. LBU -> 0x00000080. LH at 0x1 returning 0x00,0x90 -> 0xFFFF9000.
- SH 0xFFFFFFFF, data 0xAABBCCDD, ack delayed 3 cycles per byte:
  - Writes 0xDD at 0xFFFFFFFF, then 0xCC at 0x00000000.
  - Request and address held during wait cycles.
  - DONE: we=0.
- Back-to-back SW then LW: second op starts ACCESS only after DONE->IDLE. No overlap of requests.
- rst=0 during the 2nd byte of LW: next cycle mem_req=0, IDLE. A late ack is ignored. After release, a fresh LW completes correctly.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM stage: memory-op codes, bus widths, FSM states
// and small decode helpers.
package mem_access_pkg;

  localparam int REG_W      = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } memop_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  // Index of the final byte of a transfer (size - 1); unknown codes run as words.
  function automatic logic [1:0] memop_last_idx(input memop_e op);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: memop_last_idx = 2'd0;
      MEM_LH, MEM_LHU, MEM_SH: memop_last_idx = 2'd1;
      default:                 memop_last_idx = 2'd3;
    endcase
  endfunction

  function automatic logic memop_is_store(input memop_e op);
    memop_is_store = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  function automatic logic memop_is_load(input memop_e op);
    memop_is_load = (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
                    (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Sign/zero extension of an assembled load word according to the memory op.
module mem_access_load_extend
  import mem_access_pkg::*;
(
  input  memop_e           memop_i,
  input  logic [REG_W-1:0] raw_i,
  output logic [REG_W-1:0] ext_o
);

  always_comb begin
    ext_o = raw_i;
    case (memop_i)
      MEM_LB:  ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
      MEM_LBU: ext_o = {24'b0, raw_i[7:0]};
      MEM_LH:  ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
      MEM_LHU: ext_o = {16'b0, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: byte-serial load/store over a req/ack port, stalling
// the pipe while a transfer is in flight.
//
// state  | meaning
// IDLE   | no transfer; a new memory op is accepted here
// ACCESS | one byte request outstanding, advancing on mem_ack_i
// DONE   | one-cycle result presentation, then back to IDLE
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_W-1:0]      exmem_res_in,
  input  logic [REG_ADDR_W-1:0] exmem_rdest_in,
  input  logic                  exmem_we_in,
  input  logic [3:0]            exmem_memop_in,
  input  logic [REG_W-1:0]      exmem_sdata_in,
  output logic                  mem_req_o,
  output logic                  mem_wr_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [7:0]            mem_wdata_o,
  input  logic [7:0]            mem_rdata_i,
  input  logic                  mem_ack_i,
  output logic                  stallreq_mem_o,
  output logic [REG_W-1:0]      mem_res_out,
  output logic [REG_ADDR_W-1:0] mem_rdest_out,
  output logic                  mem_we_out
);

  mem_state_e state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [23:0] buf_q, buf_d;
  logic [7:0]  last_q, last_d;

  memop_e           op;
  logic             is_store;
  logic             is_load;
  logic [1:0]       last_idx;
  logic [REG_W-1:0] raw_word;
  logic [REG_W-1:0] ext_word;

  assign op       = memop_e'(exmem_memop_in);
  assign is_store = memop_is_store(op);
  assign is_load  = memop_is_load(op);
  assign last_idx = memop_last_idx(op);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      k_q     <= 2'd0;
      buf_q   <= 24'd0;
      last_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      buf_q   <= buf_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    buf_d       = buf_q;
    last_d      = last_q;
    mem_req_o   = 1'b0;
    mem_wr_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 8'd0;
    case (state_q)
      ST_IDLE: begin
        if (op != MEM_NONE) begin
          state_d = ST_ACCESS;
          k_d     = 2'd0;
          buf_d   = 24'd0;
          last_d  = 8'd0;
        end
      end
      ST_ACCESS: begin
        mem_req_o  = 1'b1;
        mem_wr_o   = is_store;
        mem_addr_o = exmem_res_in[ADDR_W-1:0] + ADDR_W'(k_q);
        case (k_q)
          2'd0:    mem_wdata_o = exmem_sdata_in[7:0];
          2'd1:    mem_wdata_o = exmem_sdata_in[15:8];
          2'd2:    mem_wdata_o = exmem_sdata_in[23:16];
          default: mem_wdata_o = exmem_sdata_in[31:24];
        endcase
        if (mem_ack_i) begin
          // The final byte goes to its own register so the word assembles
          // without shifting regardless of transfer size.
          if (is_load) begin
            if (k_q == last_idx) begin
              last_d = mem_rdata_i;
            end else begin
              case (k_q)
                2'd0:    buf_d[7:0]   = mem_rdata_i;
                2'd1:    buf_d[15:8]  = mem_rdata_i;
                default: buf_d[23:16] = mem_rdata_i;
              endcase
            end
          end
          if (k_q == last_idx) state_d = ST_DONE;
          else                 k_d     = k_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (last_idx)
      2'd0:    raw_word = {24'b0, last_q};
      2'd1:    raw_word = {16'b0, last_q, buf_q[7:0]};
      default: raw_word = {last_q, buf_q};
    endcase
  end

  mem_access_load_extend u_load_extend (
    .memop_i (op),
    .raw_i   (raw_word),
    .ext_o   (ext_word)
  );

  assign stallreq_mem_o = (op != MEM_NONE) && (state_q != ST_DONE);

  always_comb begin
    mem_res_out   = '0;
    mem_rdest_out = '0;
    mem_we_out    = 1'b0;
    if (op == MEM_NONE) begin
      mem_res_out   = exmem_res_in;
      mem_rdest_out = exmem_rdest_in;
      mem_we_out    = exmem_we_in;
    end else if (!stallreq_mem_o) begin
      mem_rdest_out = exmem_rdest_in;
      if (is_load) begin
        mem_res_out = ext_word;
        mem_we_out  = exmem_we_in;
      end
    end
  end

endmodule
